dma_engine: RTL and testbench

// Responder for the simt_group DMA command port (dmaCmd/dmaSrcAddress/dmaDstAddress/dmaWidth).
// - Moves dmaWidth 32-bit words between external DRAM (req/ack bus) and one dedicated sram_fp port.
// - Directions: d2s (DRAM->SRAM) or s2d (SRAM->DRAM). One word in flight at a time.
// - dmaBusy stalls the SIMT group until the transfer completes; dmaDone pulses once at the end.

---
 rtl/dma_engine.sv | 194 +++++++++++++++++++
 tb/tb_dma_engine.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_engine.sv
// -----------------------------------------------------------------------------
// dma_engine
//
// Responder for the SIMT group DMA command port. Moves dmaWidth 32-bit words
// between external DRAM (req/ack handshake) and a dedicated SRAM port, one word
// in flight at a time. dmaBusy stalls the SIMT group from the command cycle
// until the transfer completes; dmaDone pulses for one cycle at the end.
//
// Parameters
//   SRAM_RD_LAT    cycles sramAddr is held before sramReadData is captured
//
// Ports
//   clk            single clock
//   reset          synchronous, active-high; aborts any transfer at once
//   dmaCmd         00 none, 01 DRAM->SRAM, 10 SRAM->DRAM, 11 reserved
//   dmaSrcAddress  byte address of first source word
//   dmaDstAddress  byte address of first destination word
//   dmaWidth       word count (0..1023)
//   dmaBusy        high while a command is accepted or executing
//   dmaDone        one-cycle pulse when a transfer finishes
//   sramAddr       SRAM word address (byte address [15:2])
//   sramWe         SRAM write enable
//   sramWriteData  SRAM write data
//   sramReadData   SRAM read data
//   dramAddr       DRAM byte address
//   dramReq        DRAM request, held until dramAck
//   dramWe         DRAM write (1) / read (0), valid with dramReq
//   dramWriteData  DRAM write data
//   dramReadData   DRAM read data, valid with dramAck on reads
//   dramAck        one-cycle completion of the current DRAM request
// -----------------------------------------------------------------------------
module dma_engine #(
    parameter int SRAM_RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  dmaCmd,
    input  logic [31:0] dmaSrcAddress,
    input  logic [31:0] dmaDstAddress,
    input  logic [9:0]  dmaWidth,
    output logic        dmaBusy,
    output logic        dmaDone,
    output logic [13:0] sramAddr,
    output logic        sramWe,
    output logic [31:0] sramWriteData,
    input  logic [31:0] sramReadData,
    output logic [31:0] dramAddr,
    output logic        dramReq,
    output logic        dramWe,
    output logic [31:0] dramWriteData,
    input  logic [31:0] dramReadData,
    input  logic        dramAck
);

    localparam int WAIT_W = (SRAM_RD_LAT > 1) ? $clog2(SRAM_RD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SRAM_RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        D2S_REQ,
        D2S_WR,
        S2D_RD,
        S2D_WR,
        DONE
    } state_t;

    state_t            state;
    logic [31:0]       src;
    logic [31:0]       dst;
    logic [9:0]        remaining;
    logic [WAIT_W-1:0] wait_cnt;

    logic        cmd_valid;
    logic        last_word;
    logic [31:0] src_next;
    logic [31:0] dst_next;

    assign cmd_valid = (dmaCmd == 2'b01) || (dmaCmd == 2'b10);
    assign last_word = (remaining == 10'd1);
    assign src_next  = src + 32'd4;
    assign dst_next  = dst + 32'd4;

    // Combinational so the SIMT group stalls in the very cycle it issues the
    // command; held low while reset is asserted.
    assign dmaBusy = !reset && ((state != IDLE) || cmd_valid);

    // NOTE: every register here is assigned with <= so all state updates on an
    // edge see the pre-edge values; blocking assignments would create order races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            remaining     <= '0;
            wait_cnt      <= '0;
            dmaDone       <= 1'b0;
            sramAddr      <= '0;
            sramWe        <= 1'b0;
            sramWriteData <= '0;
            dramAddr      <= '0;
            dramReq       <= 1'b0;
            dramWe        <= 1'b0;
            dramWriteData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        src       <= dmaSrcAddress;
                        dst       <= dmaDstAddress;
                        remaining <= dmaWidth;
                        if (dmaWidth == 10'd0) begin
                            state   <= DONE;
                            dmaDone <= 1'b1;
                        end else if (dmaCmd == 2'b01) begin
                            state    <= D2S_REQ;
                            dramReq  <= 1'b1;
                            dramWe   <= 1'b0;
                            dramAddr <= dmaSrcAddress;
                        end else begin
                            state    <= S2D_RD;
                            sramAddr <= dmaSrcAddress[15:2];
                            wait_cnt <= '0;
                        end
                    end
                end

                D2S_REQ: begin
                    if (dramAck) begin
                        state         <= D2S_WR;
                        dramReq       <= 1'b0;
                        sramWe        <= 1'b1;
                        sramAddr      <= dst[15:2];
                        sramWriteData <= dramReadData;
                    end
                end

                D2S_WR: begin
                    sramWe    <= 1'b0;
                    src       <= src_next;
                    dst       <= dst_next;
                    remaining <= remaining - 10'd1;
                    if (last_word) begin
                        state   <= DONE;
                        dmaDone <= 1'b1;
                    end else begin
                        state    <= D2S_REQ;
                        dramReq  <= 1'b1;
                        dramWe   <= 1'b0;
                        dramAddr <= src_next;
                    end
                end

                // Address is held for SRAM_RD_LAT cycles; data is taken on the last.
                S2D_RD: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state         <= S2D_WR;
                        dramReq       <= 1'b1;
                        dramWe        <= 1'b1;
                        dramAddr      <= dst;
                        dramWriteData <= sramReadData;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S2D_WR: begin
                    if (dramAck) begin
                        dramReq   <= 1'b0;
                        dramWe    <= 1'b0;
                        src       <= src_next;
                        dst       <= dst_next;
                        remaining <= remaining - 10'd1;
                        if (last_word) begin
                            state   <= DONE;
                            dmaDone <= 1'b1;
                        end else begin
                            state    <= S2D_RD;
                            sramAddr <= src_next[15:2];
                            wait_cnt <= '0;
                        end
                    end
                end

                DONE: begin
                    dmaDone <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_engine.sv
// -----------------------------------------------------------------------------
// tb_dma_engine
//
// Self-checking bench for dma_engine. DRAM and SRAM are modelled as background
// patterns plus a record of words written by the DUT. Every word a command is
// expected to move is pushed to a scoreboard when the command is issued and
// popped when the DUT writes it. Each clock cycle is advanced by tick(), which
// samples outputs and drives the DRAM responder on the falling edge.
// -----------------------------------------------------------------------------
module tb_dma_engine;

    localparam int SRAM_RD_LAT = 2;

    logic        clk;
    logic        reset;
    logic [1:0]  dmaCmd;
    logic [31:0] dmaSrcAddress;
    logic [31:0] dmaDstAddress;
    logic [9:0]  dmaWidth;
    logic        dmaBusy;
    logic        dmaDone;
    logic [13:0] sramAddr;
    logic        sramWe;
    logic [31:0] sramWriteData;
    logic [31:0] sramReadData;
    logic [31:0] dramAddr;
    logic        dramReq;
    logic        dramWe;
    logic [31:0] dramWriteData;
    logic [31:0] dramReadData;
    logic        dramAck;

    dma_engine #(.SRAM_RD_LAT(SRAM_RD_LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .dmaCmd        (dmaCmd),
        .dmaSrcAddress (dmaSrcAddress),
        .dmaDstAddress (dmaDstAddress),
        .dmaWidth      (dmaWidth),
        .dmaBusy       (dmaBusy),
        .dmaDone       (dmaDone),
        .sramAddr      (sramAddr),
        .sramWe        (sramWe),
        .sramWriteData (sramWriteData),
        .sramReadData  (sramReadData),
        .dramAddr      (dramAddr),
        .dramReq       (dramReq),
        .dramWe        (dramWe),
        .dramWriteData (dramWriteData),
        .dramReadData  (dramReadData),
        .dramAck       (dramAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_dram;
        logic [31:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    logic [31:0] sram_wr [logic [13:0]];
    logic [31:0] dram_wr [logic [31:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cycles = 0, done_cnt = 0, we_cnt = 0, req_cnt = 0, overlap_cnt = 0;
    int busy0, done0, we0, req0;
    int dram_lat = 1;
    int req_age  = 0;
    logic s_busy, s_req, s_we;

    function automatic logic [31:0] dram_init(input logic [31:0] a);
        case (a)
            32'h100: return 32'd11;
            32'h104: return 32'd22;
            32'h108: return 32'd33;
            32'h10C: return 32'd44;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    function automatic logic [31:0] sram_init(input logic [13:0] w);
        case (w)
            14'd0:   return 32'd7;
            14'd1:   return 32'd8;
            14'd2:   return 32'd9;
            default: return 32'h5A5A_0000 | {18'd0, w};
        endcase
    endfunction

    function automatic logic [31:0] dram_rd(input logic [31:0] a);
        return dram_wr.exists(a) ? dram_wr[a] : dram_init(a);
    endfunction

    function automatic logic [31:0] sram_rd(input logic [13:0] w);
        return sram_wr.exists(w) ? sram_wr[w] : sram_init(w);
    endfunction

    // SRAM read port: data follows the address through one register stage,
    // so it is valid in the second cycle the address is held.
    always @(posedge clk) sramReadData <= sram_rd(sramAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input logic is_dram, input logic [31:0] addr, input logic [31:0] data);
        sb_entry_t e;
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("wr_kind", {31'd0, is_dram}, {31'd0, e.is_dram});
            check(is_dram ? "dram_wr_addr" : "sram_wr_addr", addr, e.addr);
            check(is_dram ? "dram_wr_data" : "sram_wr_data", data, e.data);
        end
    endtask

    // One clock cycle: sample and respond on the falling edge, return just
    // after the next rising edge so the caller can drive new inputs.
    task automatic tick();
        @(negedge clk);
        s_busy = dmaBusy;
        s_req  = dramReq;
        s_we   = sramWe;
        if (dmaBusy === 1'b1) busy_cycles++;
        if (dmaDone === 1'b1) done_cnt++;
        if (sramWe === 1'b1 && dramReq === 1'b1) overlap_cnt++;
        if (sramWe === 1'b1) begin
            we_cnt++;
            sram_wr[sramAddr] = sramWriteData;
            sb_check(1'b0, {18'd0, sramAddr}, sramWriteData);
        end
        if (dramReq === 1'b1 && reset === 1'b0) begin
            req_cnt++;
            if (req_age + 1 >= dram_lat) begin
                dramAck = 1'b1;
                if (dramWe === 1'b1) begin
                    dram_wr[dramAddr] = dramWriteData;
                    sb_check(1'b1, dramAddr, dramWriteData);
                end else begin
                    dramReadData = dram_rd(dramAddr);
                end
            end else begin
                dramAck = 1'b0;
            end
            req_age++;
        end else begin
            dramAck = 1'b0;
            req_age = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_snap();
        busy0 = busy_cycles;
        done0 = done_cnt;
        we0   = we_cnt;
        req0  = req_cnt;
    endtask

    task automatic push_exp(input logic [1:0] cmd, input logic [31:0] src,
                            input logic [31:0] dst, input int n);
        sb_entry_t   e;
        logic [31:0] s, d;
        for (int i = 0; i < n; i++) begin
            s = src + 32'(4 * i);
            d = dst + 32'(4 * i);
            if (cmd == 2'b01) begin
                e.is_dram = 1'b0;
                e.addr    = {18'd0, d[15:2]};
                e.data    = dram_rd(s);
            end else begin
                e.is_dram = 1'b1;
                e.addr    = d;
                e.data    = sram_rd(s[15:2]);
            end
            sb_q.push_back(e);
        end
    endtask

    // Waits (bounded) for dmaDone, then checks the cycle accounting of the transfer.
    task automatic wait_and_check(input logic [1:0] cmd, input int width, input int lat,
                                  input int ticks_before);
        int exp_busy;
        int waited;
        exp_busy = (width == 0) ? 2
                 : 2 + width * ((cmd == 2'b01) ? lat + 1 : SRAM_RD_LAT + lat);
        waited = 0;
        while (waited < exp_busy + 50 && done_cnt == done0) begin
            tick();
            waited++;
        end
        repeat (2) tick();
        check("done_latency", waited, exp_busy - 1 - ticks_before);
        check("busy_cycles", busy_cycles - busy0, exp_busy);
        check("done_count", done_cnt - done0, 1);
        check("sram_we_cycles", we_cnt - we0, (cmd == 2'b01) ? width : 0);
        check("dram_req_cycles", req_cnt - req0, width * lat);
        check("sb_drained", sb_q.size(), 0);
        check("busy_after_done", {31'd0, s_busy}, 32'd0);
    endtask

    task automatic run_xfer(input logic [1:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                            input int width, input int lat, input bit inject);
        start_snap();
        push_exp(cmd, src, dst, width);
        dram_lat      = lat;
        dmaCmd        = cmd;
        dmaSrcAddress = src;
        dmaDstAddress = dst;
        dmaWidth      = 10'(width);
        tick();
        dmaCmd = 2'b00;
        if (inject) begin
            tick();
            dmaCmd = 2'b11;
            tick();
            dmaCmd        = 2'b10;
            dmaSrcAddress = 32'h5000;
            dmaDstAddress = 32'h6000;
            dmaWidth      = 10'd7;
            tick();
            dmaCmd = 2'b00;
        end
        wait_and_check(cmd, width, lat, inject ? 3 : 0);
    endtask

    initial begin
        int waited;
        reset         = 1'b1;
        dmaCmd        = 2'b01;
        dmaSrcAddress = 32'h100;
        dmaDstAddress = 32'h10;
        dmaWidth      = 10'd4;
        dramAck       = 1'b0;
        dramReadData  = '0;
        @(posedge clk);
        #1;

        // Reset held with a pending d2s command: nothing may move.
        repeat (3) begin
            tick();
            check("rst_busy", {31'd0, s_busy}, 32'd0);
            check("rst_dram_req", {31'd0, s_req}, 32'd0);
            check("rst_sram_we", {31'd0, s_we}, 32'd0);
        end

        // Release: the held command is accepted, DRAM request follows next cycle.
        start_snap();
        push_exp(2'b01, 32'h100, 32'h10, 4);
        dram_lat = 2;
        reset    = 1'b0;
        tick();
        check("cmd_cycle_busy", {31'd0, s_busy}, 32'd1);
        check("cmd_cycle_req", {31'd0, s_req}, 32'd0);
        dmaCmd = 2'b00;
        tick();
        check("first_req", {31'd0, s_req}, 32'd1);
        wait_and_check(2'b01, 4, 2, 1);
        for (int i = 0; i < 4; i++)
            check("d2s_bank_word", sram_rd(14'(4 + i)), 32'(11 * (i + 1)));

        // SRAM -> DRAM, ack in the first request cycle.
        run_xfer(2'b10, 32'h0, 32'h2000, 3, 1, 1'b0);
        for (int i = 0; i < 3; i++)
            check("s2d_dram_word", dram_rd(32'h2000 + 32'(4 * i)), 32'(7 + i));

        // Zero-length command.
        run_xfer(2'b01, 32'h800, 32'h900, 0, 1, 1'b0);

        // Reserved command in IDLE is ignored and does not raise busy.
        dmaCmd = 2'b11;
        tick();
        check("rsvd_busy", {31'd0, s_busy}, 32'd0);
        dmaCmd = 2'b00;
        tick();
        check("rsvd_no_req", {31'd0, s_req}, 32'd0);

        // Commands issued mid-transfer are ignored.
        run_xfer(2'b01, 32'h400, 32'h80, 2, 3, 1'b1);

        // Address wrap on both sides: SRAM at 64 KiB, DRAM at 2^32.
        run_xfer(2'b10, 32'hFFF8, 32'hFFFF_FFF8, 3, 3, 1'b0);

        // Reset after two of four words: the rest must never be written.
        start_snap();
        push_exp(2'b01, 32'h300, 32'h40, 2);
        dram_lat      = 2;
        dmaCmd        = 2'b01;
        dmaSrcAddress = 32'h300;
        dmaDstAddress = 32'h40;
        dmaWidth      = 10'd4;
        tick();
        dmaCmd = 2'b00;
        waited = 0;
        while (waited < 50 && we_cnt - we0 < 2) begin
            tick();
            waited++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("abort_no_done", done_cnt - done0, 0);
        check("abort_we_count", we_cnt - we0, 2);
        check("abort_sb_drained", sb_q.size(), 0);
        check("abort_word0", 32'(sram_wr.exists(14'd16)), 32'd1);
        check("abort_word1", 32'(sram_wr.exists(14'd17)), 32'd1);
        check("abort_word2", 32'(sram_wr.exists(14'd18)), 32'd0);
        check("abort_word3", 32'(sram_wr.exists(14'd19)), 32'd0);
        check("abort_busy", {31'd0, s_busy}, 32'd0);

        // A fresh command after the abort runs to completion.
        run_xfer(2'b01, 32'h300, 32'h40, 4, 2, 1'b0);

        // Maximum width.
        run_xfer(2'b01, 32'h1_0000, 32'h0, 1023, 1, 1'b0);

        check("we_req_overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
